matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Parametrised multiplexed LED-matrix scan controller. It drives N_COL column strobes and N_ROW row lines from a double-buffered frame image. It generates its own column-slot timing from the system clock, inserts anti-ghosting blanking between columns, applies global PWM brightness, and accepts new frames via a valid/ready handshake that swaps only at frame boundaries (no tearing). It sits between the frame producer (CPU/pattern generator) and the matrix pin drivers.

## Interface
- CLK_REF, 48_000_000: system clock frequency, Hz.
- SCAN_HZ, 8_000: column-slot rate, Hz. DIV = CLK_REF/SCAN_HZ cycles per slot.
- N_COL, 8: number of columns (≥2).
- N_ROW, 8: number of rows (≥1).
- PWM_BITS, 4: brightness resolution.
- BLANK_CYC, 4: blanked cycles at start of each slot. Elaboration error unless DIV > BLANK_CYC.
- STR_ACT_LOW, 0: 1 = row lines active-low.
- CLM_ACT_LOW, 0: 1 = column strobes active-low.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  scan enable.
- BRIGHT  in  PWM_BITS  global brightness; sampled at each slot start.
- LOAD_VALID  in  1  frame offered.
- LOAD_READY  out  1  shadow buffer free.
- DAT_I  in  N_ROW*N_COL  frame; column c = DAT_I[c*N_ROW +: N_ROW], row r of that column = bit r.
- STR  out  N_ROW  row drive.
- CLM  out  N_COL  column strobe (one-hot when lit).
- FRAME_SYNC  out  1  one-cycle pulse at frame start.

## Operation
- Buffers: shadow (SHD) and display (DSP), each N_ROW*N_COL bits, plus a pending flag PND.
- LOAD_READY = !PND. A transfer occurs on a cycle with LOAD_VALID && LOAD_READY: SHD <= DAT_I, PND <= 1. DAT_I is ignored when no transfer occurs.
- Scan counters:
  - slot counter SC runs 0..DIV-1.
  - column counter COL runs 0..N_COL-1 and advances when SC wraps.
  - Frame boundary: COL wraps N_COL-1→0 together with SC wrap.
- Swap: at the frame boundary, if PND then DSP <= SHD and PND <= 0. With PND=0 at the boundary, DSP is held.
- Swap and transfer on the same cycle cannot collide, because READY=0 whenever PND=1. A transfer on the boundary cycle with PND=0 is displayed from the next boundary.
- Slot phases:
  - SC < BLANK_CYC: BLANK.
  - Otherwise: ON while (SC-BLANK_CYC) < ON_N, else OFF.
  - ON_N = ((DIV-BLANK_CYC)*BRIGHT) >> PWM_BITS, computed at SC=0 and held for the slot. Arithmetic width is clog2(DIV)+PWM_BITS, unsigned.
- Outputs during ON: CLM = one-hot(COL); STR = DSP column COL. Each is inverted per its ACT_LOW parameter.
- Outputs during BLANK/OFF: both buses at their inactive level (all-0, or all-1 if ACT_LOW).
- EN=0:
  - SC and COL forced to 0; outputs inactive; FRAME_SYNC low.
  - Handshake still works. A pending frame swaps immediately (next cycle), so re-enable shows the newest frame.
  - Scan restarts at COL=0, SC=0 on the cycle after EN rises.
- BRIGHT=0 gives dark slots. Changes to BRIGHT take effect at the next slot start only.

## Timing
- STR, CLM and FRAME_SYNC are registered, one cycle after the counter state that produced them.
- FRAME_SYNC is high for exactly one cycle, coincident with the first output cycle of COL=0 (which is BLANK).
- Frame period: N_COL*DIV cycles. An accepted frame appears at most N_COL*DIV+1 cycles after the transfer cycle.
- Reset values:
  - STR and CLM at inactive levels.
  - FRAME_SYNC=0.
  - LOAD_READY=1 (PND=0).
  - SHD=DSP=0; SC=COL=0.
- RST mid-frame: immediate return to the reset state. A pending frame is lost.

## Structure
- Shared package matrix_scan_pkg holds:
  - DIV and width constants (clog2 of DIV, N_COL, and the ON_N product).
  - Elaboration check function (DIV > BLANK_CYC).
  - Polarity helper function applying ACT_LOW inversion.
- One sub-module, matrix_frame_buf: SHD/DSP/PND plus the handshake and swap logic. Inputs are swap_req (boundary or EN=0) and a column select; it returns the column word.
- Top level holds the counters, PWM compare, and output registers.

## Test plan
Common setup: CLK_REF=48_000_000, SCAN_HZ=2_000_000 (DIV=24), N_COL=N_ROW=8, BLANK_CYC=4, PWM_BITS=2, polarities 0.
- Reset then EN=1, BRIGHT=3, load DAT_I=64'h0102040810204080 → per slot: 4 blank cycles, 15 ON cycles, 5 OFF. During COL0 ON, CLM=8'h01 and STR=8'h80. FRAME_SYNC pulses every 192 cycles.
- BRIGHT=2 → 10 ON cycles per slot. BRIGHT=0 → STR=CLM=0 throughout. A change mid-slot applies only from the next slot.
- Load frame A, then offer frame B mid-frame → B accepted, READY=0 until the boundary. A is shown for the whole current frame; B appears from the next COL0 slot, and READY returns to 1 on that cycle.
- Hold LOAD_VALID with READY=0 → no capture and DSP unchanged. Assert VALID on the boundary cycle with PND=0 → the frame displays one frame later.
- EN=0 with a pending frame → outputs inactive, swap happens next cycle. On re-enable, COL=0 and the new frame is shown.
- STR_ACT_LOW=CLM_ACT_LOW=1 → reset values are all-ones. During COL0 ON, CLM=8'hFE and STR is inverted. Asserting RST mid-slot → outputs inactive immediately and READY=1.

Source files
------------

// File: rtl/matrix_scan_pkg.sv
// Shared types and helpers for the multiplexed LED-matrix scan controller.
package matrix_scan_pkg;

   // Phase of the current column slot.
   typedef enum logic [1:0] {
      PhBlank,
      PhOn,
      PhOff
   } phase_e;

   // System-clock cycles per column slot.
   function automatic int unsigned div_of(input int unsigned clk_ref,
                                          input int unsigned scan_hz);
      return clk_ref / scan_hz;
   endfunction

   // Counter width for a counter running 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : unsigned'($clog2(n));
   endfunction

   // Width of the ON_N product: slot span times brightness.
   function automatic int unsigned on_w(input int unsigned div, input int unsigned pwm_bits);
      return cnt_w(div) + pwm_bits;
   endfunction

   // Slot must be longer than the blanking interval, and a scan needs two columns.
   function automatic bit cfg_ok(input int unsigned div, input int unsigned blank_cyc,
                                 input int unsigned n_col, input int unsigned n_row);
      return (div > blank_cyc) && (n_col >= 2) && (n_row >= 1);
   endfunction

   // Map a logical "lit" bit onto the pin level for the given polarity.
   function automatic logic pol_bit(input logic v, input bit act_low);
      return v ^ act_low;
   endfunction

endpackage

// File: rtl/matrix_frame_buf.sv
// Double-buffered frame store: shadow buffer filled by the valid/ready
// handshake, display buffer updated only when the scanner requests a swap.
module matrix_frame_buf
   import matrix_scan_pkg::*;
#(
   parameter int unsigned N_COL = 8,
   parameter int unsigned N_ROW = 8,
   parameter int unsigned COL_W = cnt_w(N_COL)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [N_ROW*N_COL-1:0] dat,
   input  logic                   swap_req,
   input  logic [COL_W-1:0]       col_sel,
   output logic [N_ROW-1:0]       col_word
);

   localparam int unsigned FRAME_W = N_ROW * N_COL;

   logic [FRAME_W-1:0] shd_q, shd_d;
   logic [FRAME_W-1:0] dsp_q, dsp_d;
   logic               pnd_q, pnd_d;

   // Shadow accepts a frame only while nothing is pending, so a transfer and
   // a swap can never land on the same cycle.
   assign load_ready = ~pnd_q;

   // Next-state for the transfer and boundary swap.
   always_comb begin
      shd_d = shd_q;
      dsp_d = dsp_q;
      pnd_d = pnd_q;
      if (load_valid && !pnd_q) begin
         shd_d = dat;
         pnd_d = 1'b1;
      end else if (swap_req && pnd_q) begin
         dsp_d = shd_q;
         pnd_d = 1'b0;
      end
   end

   // Buffer and pending-flag registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shd_q <= '0;
         dsp_q <= '0;
         pnd_q <= 1'b0;
      end else begin
         shd_q <= shd_d;
         dsp_q <= dsp_d;
         pnd_q <= pnd_d;
      end
   end

   // Column read mux; out-of-range selects read as all-dark.
   always_comb begin
      col_word = '0;
      for (int c = 0; c < N_COL; c++) begin
         if (col_sel == COL_W'(c)) begin
            col_word = dsp_q[c*N_ROW +: N_ROW];
         end
      end
   end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Multiplexed LED-matrix scan controller: slot/column counters, per-slot
// blanking and PWM, registered row/column drive and frame-sync pulse.
module matrix_scan_ctrl
   import matrix_scan_pkg::*;
#(
   parameter int unsigned CLK_REF     = 48_000_000,
   parameter int unsigned SCAN_HZ     = 8_000,
   parameter int unsigned N_COL       = 8,
   parameter int unsigned N_ROW       = 8,
   parameter int unsigned PWM_BITS    = 4,
   parameter int unsigned BLANK_CYC   = 4,
   parameter bit          STR_ACT_LOW = 1'b0,
   parameter bit          CLM_ACT_LOW = 1'b0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   EN,
   input  logic [PWM_BITS-1:0]    BRIGHT,
   input  logic                   LOAD_VALID,
   output logic                   LOAD_READY,
   input  logic [N_ROW*N_COL-1:0] DAT_I,
   output logic [N_ROW-1:0]       STR,
   output logic [N_COL-1:0]       CLM,
   output logic                   FRAME_SYNC
);

   localparam int unsigned DIV   = div_of(CLK_REF, SCAN_HZ);
   localparam int unsigned SC_W  = cnt_w(DIV);
   localparam int unsigned COL_W = cnt_w(N_COL);
   localparam int unsigned ON_W  = on_w(DIV, PWM_BITS);

   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(DIV - 1);
   localparam logic [SC_W-1:0]  SC_BLANK = SC_W'(BLANK_CYC);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);
   localparam logic [ON_W-1:0]  ON_SPAN  = ON_W'(DIV - BLANK_CYC);
   localparam logic [N_ROW-1:0] STR_IDLE = {N_ROW{pol_bit(1'b0, STR_ACT_LOW)}};
   localparam logic [N_COL-1:0] CLM_IDLE = {N_COL{pol_bit(1'b0, CLM_ACT_LOW)}};

   if (!cfg_ok(DIV, BLANK_CYC, N_COL, N_ROW)) begin : g_cfg_err
      $error("matrix_scan_ctrl: need DIV > BLANK_CYC, N_COL >= 2, N_ROW >= 1");
   end

   logic [SC_W-1:0]  sc_q, sc_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ON_W-1:0]  on_n_q, on_n_d;
   logic [ON_W-1:0]  on_calc;
   logic [ON_W-1:0]  on_now;
   logic [SC_W-1:0]  sc_rel;
   logic             slot_end;
   logic             col_last;
   logic             swap_req;
   phase_e           phase;
   logic [N_ROW-1:0] col_word;
   logic [N_COL-1:0] clm_hot;
   logic [N_ROW-1:0] str_q, str_d;
   logic [N_COL-1:0] clm_q, clm_d;
   logic             sync_q, sync_d;

   assign slot_end = (sc_q == SC_LAST);
   assign col_last = (col_q == COL_LAST);

   // Frame boundary while scanning, or any cycle while disabled, so a frame
   // loaded during EN=0 is already on display when scanning resumes.
   assign swap_req = ~EN | (slot_end & col_last);

   matrix_frame_buf #(
      .N_COL (N_COL),
      .N_ROW (N_ROW),
      .COL_W (COL_W)
   ) u_frame_buf (
      .CLK        (CLK),
      .RST        (RST),
      .load_valid (LOAD_VALID),
      .load_ready (LOAD_READY),
      .dat        (DAT_I),
      .swap_req   (swap_req),
      .col_sel    (col_q),
      .col_word   (col_word)
   );

   // Slot and column counters; held at zero while disabled.
   always_comb begin
      sc_d  = sc_q;
      col_d = col_q;
      if (!EN) begin
         sc_d  = '0;
         col_d = '0;
      end else if (slot_end) begin
         sc_d  = '0;
         col_d = col_last ? '0 : col_q + 1'b1;
      end else begin
         sc_d = sc_q + 1'b1;
      end
   end

   // ON length for the slot: sampled from BRIGHT at SC=0, held otherwise.
   always_comb begin
      on_calc = (ON_SPAN * ON_W'(BRIGHT)) >> PWM_BITS;
      on_now  = (sc_q == '0) ? on_calc : on_n_q;
      on_n_d  = on_now;
   end

   // Slot phase: blank first, then ON for on_now cycles, then OFF.
   always_comb begin
      sc_rel = sc_q - SC_BLANK;
      phase  = PhOff;
      if (sc_q < SC_BLANK) begin
         phase = PhBlank;
      end else if (ON_W'(sc_rel) < on_now) begin
         phase = PhOn;
      end
   end

   // Next output levels; everything inactive unless scanning and in ON.
   always_comb begin
      str_d   = STR_IDLE;
      clm_d   = CLM_IDLE;
      sync_d  = 1'b0;
      clm_hot = N_COL'(1) << col_q;
      if (EN) begin
         sync_d = (sc_q == '0) && (col_q == '0);
         if (phase == PhOn) begin
            for (int r = 0; r < N_ROW; r++) begin
               str_d[r] = pol_bit(col_word[r], STR_ACT_LOW);
            end
            for (int c = 0; c < N_COL; c++) begin
               clm_d[c] = pol_bit(clm_hot[c], CLM_ACT_LOW);
            end
         end
      end
   end

   // Counter, PWM-length and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sc_q   <= '0;
         col_q  <= '0;
         on_n_q <= '0;
         str_q  <= STR_IDLE;
         clm_q  <= CLM_IDLE;
         sync_q <= 1'b0;
      end else begin
         sc_q   <= sc_d;
         col_q  <= col_d;
         on_n_q <= on_n_d;
         str_q  <= str_d;
         clm_q  <= clm_d;
         sync_q <= sync_d;
      end
   end

   assign STR        = str_q;
   assign CLM        = clm_q;
   assign FRAME_SYNC = sync_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl at DIV=24, 8x8, BLANK_CYC=4, PWM_BITS=2.
// A second instance with both polarities active-low runs on the same stimulus.
module tb_matrix_scan_ctrl;

   localparam int DIV   = 24;
   localparam int BLANK = 4;
   localparam int NC    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  bright;
   logic        load_valid;
   logic        load_ready, ready_n;
   logic [63:0] dat;
   logic [7:0]  str, str_n;
   logic [7:0]  clm, clm_n;
   logic        frame_sync, fs_n;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   matrix_scan_ctrl #(
      .CLK_REF(48_000_000), .SCAN_HZ(2_000_000), .N_COL(8), .N_ROW(8),
      .PWM_BITS(2), .BLANK_CYC(4), .STR_ACT_LOW(1'b0), .CLM_ACT_LOW(1'b0)
   ) dut (
      .CLK(clk), .RST(rst), .EN(en), .BRIGHT(bright), .LOAD_VALID(load_valid),
      .LOAD_READY(load_ready), .DAT_I(dat), .STR(str), .CLM(clm), .FRAME_SYNC(frame_sync)
   );

   matrix_scan_ctrl #(
      .CLK_REF(48_000_000), .SCAN_HZ(2_000_000), .N_COL(8), .N_ROW(8),
      .PWM_BITS(2), .BLANK_CYC(4), .STR_ACT_LOW(1'b1), .CLM_ACT_LOW(1'b1)
   ) dut_n (
      .CLK(clk), .RST(rst), .EN(en), .BRIGHT(bright), .LOAD_VALID(load_valid),
      .LOAD_READY(ready_n), .DAT_I(dat), .STR(str_n), .CLM(clm_n), .FRAME_SYNC(fs_n)
   );

   typedef struct {
      logic [1:0]  bright;
      logic [63:0] frame;
      int          exp_on;
      logic [7:0]  exp_clm0;
      logic [7:0]  exp_str0;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs(input string name);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!frame_sync && k < 400);
      check(name, 64'(frame_sync), 64'd1);
   endtask

   task automatic load(input logic [63:0] d);
      int k = 0;
      while (!load_ready && k < 400) begin
         tick();
         k++;
      end
      check("load_ready", 64'(load_ready), 64'd1);
      load_valid = 1'b1;
      dat        = d;
      tick();
      load_valid = 1'b0;
   endtask

   // Starts on a FRAME_SYNC interval and checks one whole frame cycle by cycle.
   task automatic grab_frame(input string name, input logic [63:0] frm, input int exp_on,
                             output logic [7:0] clm0, output logic [7:0] str0);
      int         err, err_n, on0;
      logic [7:0] e_clm, e_str;
      logic       on_exp;
      err = 0; err_n = 0; on0 = 0; clm0 = '0; str0 = '0;
      for (int i = 0; i < NC * DIV; i++) begin
         int c, s;
         c      = i / DIV;
         s      = i % DIV;
         on_exp = (s >= BLANK) && (s < BLANK + exp_on);
         e_clm  = on_exp ? 8'(1 << c) : 8'h00;
         e_str  = on_exp ? frm[c*8 +: 8] : 8'h00;
         if (clm !== e_clm || str !== e_str || frame_sync !== (i == 0)) err++;
         if (clm_n !== ~e_clm || str_n !== ~e_str || fs_n !== (i == 0)) err_n++;
         if (i < DIV && clm != '0) begin
            on0++;
            clm0 = clm;
            str0 = str;
         end
         tick();
      end
      check({name, "_on_col0"}, 64'(on0), 64'(exp_on));
      check({name, "_frame"}, 64'(err), 64'd0);
      check({name, "_frame_lowpol"}, 64'(err_n), 64'd0);
      check({name, "_period"}, 64'(frame_sync), 64'd1);
   endtask

   initial begin
      logic [7:0]  c0, s0;
      logic [63:0] fa, fb, fc, fd, fe, ff;
      int          on_a, on_b, a_err, ready_k, idle_err;

      vecs[0] = '{2'd2, 64'h0102040810204080, 10, 8'h01, 8'h80};
      vecs[1] = '{2'd0, 64'hFFFFFFFFFFFFFFFF,  0, 8'h00, 8'h00};
      vecs[2] = '{2'd1, 64'hFF00AA5512345678,  5, 8'h01, 8'h78};
      vecs[3] = '{2'd3, 64'h0102040810204080, 15, 8'h01, 8'h80};
      fa = 64'h1122334455667788;
      fb = 64'h8040201008040201;
      fc = 64'hDEADBEEFCAFEF00D;
      fd = 64'h00FF00FF00FF00FF;
      fe = 64'hA5A5A5A55A5A5A5A;
      ff = 64'h123456789ABCDEF0;

      rst = 1'b1; en = 1'b0; bright = 2'd0; load_valid = 1'b0; dat = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_str", 64'(str), 64'h00);
      check("rst_clm", 64'(clm), 64'h00);
      check("rst_sync", 64'(frame_sync), 64'd0);
      check("rst_ready", 64'(load_ready), 64'd1);
      check("rst_str_lowpol", 64'(str_n), 64'hFF);
      check("rst_clm_lowpol", 64'(clm_n), 64'hFF);
      check("rst_ready_lowpol", 64'(ready_n), 64'd1);
      rst = 1'b0;
      tick();

      // Table: brightness levels and frames, each checked over a full frame.
      for (int v = 0; v < 4; v++) begin
         bright = vecs[v].bright;
         en     = 1'b1;
         load(vecs[v].frame);
         wait_fs("vec_fs1");
         wait_fs("vec_fs2");
         grab_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].exp_on, c0, s0);
         check($sformatf("vec%0d_clm0", v), 64'(c0), 64'(vecs[v].exp_clm0));
         check($sformatf("vec%0d_str0", v), 64'(s0), 64'(vecs[v].exp_str0));
      end

      // BRIGHT change mid-slot: COL0 keeps 15 ON cycles, COL1 gets 5.
      bright = 2'd1;
      on_a = 0; on_b = 0;
      for (int i = 0; i < 2 * DIV; i++) begin
         if (clm != '0) begin
            if (i < DIV) on_a++;
            else on_b++;
         end
         tick();
      end
      check("bright_mid_col0", 64'(on_a), 64'd15);
      check("bright_mid_col1", 64'(on_b), 64'd5);
      bright = 2'd3;
      wait_fs("bright_restore_fs");

      // Frame A displayed, then B offered mid-frame while C is held with READY=0.
      load(fa);
      wait_fs("a_fs1");
      wait_fs("a_fs2");
      repeat (50) tick();
      load_valid = 1'b1;
      dat        = fb;
      tick();
      check("b_ready_low", 64'(load_ready), 64'd0);
      dat     = fc;
      a_err   = 0;
      ready_k = -1;
      for (int k = 0; k < 400; k++) begin
         if (load_ready) begin
            load_valid = 1'b0;
            ready_k    = k;
            break;
         end
         if (clm == '0) begin
            if (str != '0) a_err++;
         end else begin
            logic hit;
            hit = 1'b0;
            for (int c = 0; c < NC; c++) begin
               if (clm == 8'(1 << c)) begin
                  hit = 1'b1;
                  if (str !== fa[c*8 +: 8]) a_err++;
               end
            end
            if (!hit) a_err++;
         end
         tick();
      end
      load_valid = 1'b0;
      check("a_untorn", 64'(a_err), 64'd0);
      check("ready_low_len", 64'(ready_k), 64'd140);
      tick();
      check("b_sync", 64'(frame_sync), 64'd1);
      check("b_ready_at_swap", 64'(load_ready), 64'd1);
      grab_frame("b", fb, 15, c0, s0);

      // VALID on the boundary cycle with nothing pending: shown one frame later.
      repeat (190) tick();
      load_valid = 1'b1;
      dat        = fd;
      tick();
      load_valid = 1'b0;
      check("d_captured", 64'(load_ready), 64'd0);
      tick();
      check("d_boundary_sync", 64'(frame_sync), 64'd1);
      grab_frame("b_again", fb, 15, c0, s0);
      check("d_ready_at_swap", 64'(load_ready), 64'd1);
      grab_frame("d", fd, 15, c0, s0);

      // EN=0 with a pending frame: dark, swap next cycle, restart at COL0.
      load_valid = 1'b1;
      dat        = fe;
      tick();
      load_valid = 1'b0;
      en         = 1'b0;
      tick();
      check("dis_str", 64'(str), 64'h00);
      check("dis_clm", 64'(clm), 64'h00);
      check("dis_swap_ready", 64'(load_ready), 64'd1);
      idle_err = 0;
      for (int i = 0; i < 20; i++) begin
         if (str != '0 || clm != '0 || frame_sync || str_n != 8'hFF || clm_n != 8'hFF)
            idle_err++;
         tick();
      end
      check("dis_idle", 64'(idle_err), 64'd0);
      en = 1'b1;
      tick();
      check("reen_sync", 64'(frame_sync), 64'd1);
      grab_frame("e", fe, 15, c0, s0);

      // RST mid-slot with a pending frame: immediate idle, pending frame lost.
      load_valid = 1'b1;
      dat        = ff;
      tick();
      load_valid = 1'b0;
      repeat (28) tick();
      check("col1_on_clm", 64'(clm), 64'h02);
      check("col1_on_clm_lowpol", 64'(clm_n), 64'hFD);
      check("col1_pending", 64'(load_ready), 64'd0);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_str", 64'(str), 64'h00);
      check("rst_mid_clm", 64'(clm), 64'h00);
      check("rst_mid_ready", 64'(load_ready), 64'd1);
      check("rst_mid_str_lowpol", 64'(str_n), 64'hFF);
      check("rst_mid_clm_lowpol", 64'(clm_n), 64'hFF);
      tick();
      rst = 1'b0;
      wait_fs("post_rst_fs");
      grab_frame("zero", 64'h0, 15, c0, s0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
